// File: rtl/conv_result_reorder_if.sv
// Handshake bundle between the convolution engine, the reorder buffer and
// the downstream consumer. The slave modport is the reorder buffer's view.
interface conv_result_reorder_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_finish;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, in_data, in_finish, out_ready,
        input  out_valid, out_data, out_last, busy, err
    );

    modport slave (
        input  in_valid, in_data, in_finish, out_ready,
        output out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/conv_result_reorder.sv
// Reorder buffer for 3x3 convolution results: captures a serpentine-ordered
// frame (even rows left->right, odd rows right->left), optionally clamps
// negatives to zero, then streams the frame out in raster order.
module conv_result_reorder #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 5,
    parameter int OUT_H  = 5,
    parameter int RELU   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_result_reorder_if.slave  bus
);
    localparam int N      = OUT_W * OUT_H;
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = $clog2(N + 1);
    localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [PTR_W-1:0]  N_CNT     = PTR_W'(N);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [DATA_W-1:0]   mem_q [N];

    logic [PTR_W-1:0]    fill_cnt;
    logic [PTR_W-1:0]    cnt_inc;
    logic [PTR_W-1:0]    fin_cnt;
    logic [COL_W-1:0]    wr_col;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_word;
    logic                wr_en;
    logic [ADDR_W-1:0]   nxt_ptr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;

    // Write-side addressing: serpentine column fold and ReLU clamp.
    always_comb begin
        fill_cnt = PTR_W'(row_q) * PTR_W'(OUT_W) + PTR_W'(col_q);
        cnt_inc  = fill_cnt + PTR_W'(1);
        fin_cnt  = bus.in_valid ? cnt_inc : fill_cnt;
        wr_col   = row_q[0] ? (COL_LAST - col_q) : col_q;
        wr_addr  = ADDR_W'(PTR_W'(row_q) * PTR_W'(OUT_W) + PTR_W'(wr_col));
        wr_word  = ((RELU != 0) && bus.in_data[DATA_W-1]) ? '0 : bus.in_data;
        wr_en    = (state_q == FILL) && bus.in_valid;
    end

    // Read-side addressing: word 0 when a frame completes, else the next word.
    // A same-cycle write to the read address is forwarded (only possible when N=1).
    always_comb begin
        nxt_ptr = rd_ptr_q + ADDR_W'(1);
        rd_addr = (state_q == FILL) ? '0 : nxt_ptr;
        rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_word : mem_q[rd_addr];
    end

    // Frame buffer storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // Next-state logic for fill counters, drain pointer and output registers.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        err_d       = err_q;
        out_data_d  = out_data_q;

        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    if (cnt_inc == N_CNT) begin
                        state_d     = DRAIN;
                        row_d       = '0;
                        col_d       = '0;
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        out_last_d  = (N == 1);
                        out_data_d  = rd_word;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                // Finish uses the count including a same-cycle word; a full count is legal.
                if (bus.in_finish && (fin_cnt != '0) && (fin_cnt != N_CNT)) begin
                    err_d = 1'b1;
                    row_d = '0;
                    col_d = '0;
                end
            end
            DRAIN: begin
                if (bus.in_valid) begin
                    err_d = 1'b1;
                end
                if (out_valid_q && bus.out_ready) begin
                    if (rd_ptr_q == ADDR_LAST) begin
                        state_d     = FILL;
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        rd_ptr_d   = nxt_ptr;
                        out_data_d = rd_word;
                        out_last_d = (nxt_ptr == ADDR_LAST);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_q       <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_conv_result_reorder.sv
// Bench for conv_result_reorder: two instances (RELU=0 and RELU=1) share the
// same stimulus; each has its own expected-output queue checked on transfer.
module tb_conv_result_reorder;
    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_result_reorder_if #(.DATA_W(16)) if0 ();
    conv_result_reorder_if #(.DATA_W(16)) if1 ();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_data   = if0.in_data;
    assign if1.in_finish = if0.in_finish;
    assign if1.out_ready = if0.out_ready;

    conv_result_reorder #(.DATA_W(16), .OUT_W(W), .OUT_H(H), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    conv_result_reorder #(.DATA_W(16), .OUT_W(W), .OUT_H(H), .RELU(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] frame_v [N];
    int xfer0 = 0, xfer1 = 0, idx0 = 0, idx1 = 0;
    logic stall0 = 1'b0, stall1 = 1'b0;
    logic [15:0] pd0 = '0, pd1 = '0;
    logic pl0 = 1'b0, pl1 = 1'b0;

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall0 = 1'b0; stall1 = 1'b0; idx0 = 0; idx1 = 0;
            end else begin
                if (stall0) begin
                    total++;
                    if (if0.out_data !== pd0 || if0.out_last !== pl0) begin
                        bad++;
                        $display("FAIL stall_hold0 got data=%h last=%b want data=%h last=%b", if0.out_data, if0.out_last, pd0, pl0);
                    end
                end
                if (if0.out_valid && if0.out_ready) begin
                    total++;
                    if (q0.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected0 got data=%h want no output", if0.out_data);
                    end else begin
                        e = q0.pop_front();
                        if (if0.out_data !== e || if0.out_last !== (idx0 == N - 1)) begin
                            bad++;
                            $display("FAIL out0[%0d] got data=%h last=%b want data=%h last=%b", idx0, if0.out_data, if0.out_last, e, (idx0 == N - 1));
                        end
                    end
                    idx0 = (idx0 == N - 1) ? 0 : idx0 + 1;
                    xfer0++;
                end
                stall0 = if0.out_valid && !if0.out_ready;
                pd0 = if0.out_data;
                pl0 = if0.out_last;

                if (stall1) begin
                    total++;
                    if (if1.out_data !== pd1 || if1.out_last !== pl1) begin
                        bad++;
                        $display("FAIL stall_hold1 got data=%h last=%b want data=%h last=%b", if1.out_data, if1.out_last, pd1, pl1);
                    end
                end
                if (if1.out_valid && if1.out_ready) begin
                    total++;
                    if (q1.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected1 got data=%h want no output", if1.out_data);
                    end else begin
                        e = q1.pop_front();
                        if (if1.out_data !== e || if1.out_last !== (idx1 == N - 1)) begin
                            bad++;
                            $display("FAIL out1[%0d] got data=%h last=%b want data=%h last=%b", idx1, if1.out_data, if1.out_last, e, (idx1 == N - 1));
                        end
                    end
                    idx1 = (idx1 == N - 1) ? 0 : idx1 + 1;
                    xfer1++;
                end
                stall1 = if1.out_valid && !if1.out_ready;
                pd1 = if1.out_data;
                pl1 = if1.out_last;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_finish = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q0.delete(); q1.delete();
    endtask

    // Raster position i holds the word that arrived k-th in serpentine order.
    task automatic push_expected();
        int r, c, k;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            k = r * W + (((r % 2) == 1) ? (W - 1 - c) : c);
            q0.push_back(frame_v[k]);
            q1.push_back(frame_v[k][15] ? 16'h0000 : frame_v[k]);
        end
    endtask

    task automatic send_words(input int lo, input int hi, input logic fin_last);
        for (int k = lo; k <= hi; k++) begin
            if0.in_valid = 1'b1;
            if0.in_data = frame_v[k];
            if0.in_finish = fin_last && (k == hi);
            @(posedge clk); #1;
        end
        if0.in_valid = 1'b0;
        if0.in_finish = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((if0.busy || if1.busy || q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s_timeout got busy=%b pending=%0d want idle", name, if0.busy, q0.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (if0.out_valid !== 1'b0 || if0.out_last !== 1'b0 || if0.busy !== 1'b0 || if0.err !== 1'b0 || if0.out_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state got v=%b l=%b b=%b e=%b d=%h want 0 0 0 0 0000", if0.out_valid, if0.out_last, if0.busy, if0.err, if0.out_data);
        end
    endtask

    task automatic test_serpentine();
        int cnt = 0;
        int x;
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(k + 1);
        push_expected();
        x = xfer0;
        send_words(0, N - 2, 1'b0);
        total++;
        if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0) begin
            bad++;
            $display("FAIL early_valid got v=%b b=%b want 0 0", if0.out_valid, if0.busy);
        end
        send_words(N - 1, N - 1, 1'b0);
        total++;
        if (if0.out_valid !== 1'b1 || if0.busy !== 1'b1 || if0.out_data !== 16'd1) begin
            bad++;
            $display("FAIL first_word got v=%b b=%b d=%h want 1 1 0001", if0.out_valid, if0.busy, if0.out_data);
        end
        while (if0.busy && cnt < 100) begin
            cnt++; @(posedge clk); #1;
        end
        total++;
        if (cnt != N) begin
            bad++;
            $display("FAIL busy_cycles got %0d want %0d", cnt, N);
        end
        wait_idle("serp");
        total++;
        if (xfer0 - x != N || if0.err !== 1'b0) begin
            bad++;
            $display("FAIL serp_count got xfers=%0d err=%b want %0d 0", xfer0 - x, if0.err, N);
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat = 4'b1001;
        int i = 0;
        int x;
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(k + 1);
        push_expected();
        x = xfer0;
        send_words(0, N - 1, 1'b0);
        while (if0.busy && i < 400) begin
            if0.out_ready = pat[3 - (i % 4)];
            @(posedge clk); #1; i++;
        end
        if0.out_ready = 1'b1;
        wait_idle("stall");
        total++;
        if (xfer0 - x != N || if0.err !== 1'b0) begin
            bad++;
            $display("FAIL stall_count got xfers=%0d err=%b want %0d 0", xfer0 - x, if0.err, N);
        end
    endtask

    task automatic test_relu();
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = ((k % 2) == 0) ? 16'h0040 : 16'hFFC0;
        if0.in_finish = 1'b1;
        @(posedge clk); #1;
        if0.in_finish = 1'b0;
        push_expected();
        send_words(0, N - 1, 1'b1);
        wait_idle("relu");
        total++;
        if (if0.err !== 1'b0 || if1.err !== 1'b0) begin
            bad++;
            $display("FAIL relu_err got err0=%b err1=%b want 0 0", if0.err, if1.err);
        end
    endtask

    task automatic test_finish_abort();
        logic seen = 1'b0;
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(k + 1);
        send_words(0, 9, 1'b0);
        if0.in_finish = 1'b1;
        @(posedge clk); #1;
        if0.in_finish = 1'b0;
        total++;
        if (if0.err !== 1'b1 || if1.err !== 1'b1) begin
            bad++;
            $display("FAIL abort_err got err0=%b err1=%b want 1 1", if0.err, if1.err);
        end
        repeat (30) begin
            @(posedge clk); #1;
            if (if0.out_valid || if0.busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_output got out_valid_seen=%b want 0", seen);
        end
        for (int k = 0; k < N; k++) frame_v[k] = 16'(100 + k);
        push_expected();
        send_words(0, N - 1, 1'b0);
        wait_idle("abort");
        total++;
        if (if0.err !== 1'b1) begin
            bad++;
            $display("FAIL abort_sticky got err=%b want 1", if0.err);
        end
    endtask

    task automatic test_drain_drop();
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(k + 1);
        push_expected();
        if0.out_ready = 1'b0;
        send_words(0, N - 1, 1'b0);
        if0.in_valid = 1'b1;
        if0.in_data = 16'h7777;
        repeat (2) begin @(posedge clk); #1; end
        if0.in_valid = 1'b0;
        total++;
        if (if0.err !== 1'b1 || if0.out_data !== 16'd1 || if0.busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_err got err=%b d=%h b=%b want 1 0001 1", if0.err, if0.out_data, if0.busy);
        end
        if0.out_ready = 1'b1;
        wait_idle("drop");
    endtask

    task automatic test_reset_mid_drain();
        int x;
        int n = 0;
        do_reset();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(k + 1);
        push_expected();
        send_words(0, N - 1, 1'b0);
        x = xfer0;
        if0.in_valid = 1'b1;
        if0.in_data = 16'h7777;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        total++;
        if (if0.err !== 1'b1) begin
            bad++;
            $display("FAIL middrain_err got err=%b want 1", if0.err);
        end
        while (xfer0 - x < 12 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (if0.out_valid !== 1'b0 || if0.busy !== 1'b0 || if0.err !== 1'b0 || if0.out_last !== 1'b0 || xfer0 - x != 12) begin
            bad++;
            $display("FAIL midreset got v=%b b=%b e=%b l=%b xfers=%0d want 0 0 0 0 12", if0.out_valid, if0.busy, if0.err, if0.out_last, xfer0 - x);
        end
        rst = 1'b0;
        q0.delete(); q1.delete();
        for (int k = 0; k < N; k++) frame_v[k] = 16'(200 + k);
        push_expected();
        send_words(0, N - 1, 1'b0);
        wait_idle("after_reset");
        total++;
        if (if0.err !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_err got err=%b want 0", if0.err);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_finish = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_serpentine();
        test_stall();
        test_relu();
        test_finish_abort();
        test_drain_drop();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_result_reorder.md
Name: conv_result_reorder

Overview:
- Downstream stage of the 3x3 convolution engine.
- Captures the engine's 16-bit results, which arrive in serpentine row order (even rows left->right, odd rows right->left), into an OUT_W x OUT_H buffer.
- Optionally applies ReLU, then streams the frame out in raster order over a valid/ready handshake to the next layer or the host readout.

Parameters:
- DATA_W, 16: result word width; matches the engine's signed fixed-point output.
- OUT_W, 5: output feature-map width (columns).
- OUT_H, 5: output feature-map height (rows).
- RELU, 0: 1 = negative inputs (in_data[DATA_W-1]=1) stored as 0; 0 = stored unchanged.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  engine result strobe; one word per cycle when high.
- in_data  in  DATA_W  engine result, signed.
- in_finish  in  1  engine end-of-frame pulse.
- out_valid  out  1  out_data holds a valid raster-order word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  DATA_W  raster-order result.
- out_last  out  1  high with the final word (index N-1) of the frame.
- busy  out  1  high while draining; inputs are not accepted.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- N = OUT_W*OUT_H. Buffer is N x DATA_W, register or inferred RAM, with a registered read so out_data comes from a register.
- Reset: state FILL; row/col/rd_ptr = 0; out_valid, out_last, busy, err = 0; out_data = 0. Buffer contents are not reset. Reset mid-FILL or mid-DRAIN aborts the frame with no output.
- FILL state, on each in_valid:
  - Write buf[row*OUT_W + c], where c = col for even row and OUT_W-1-col for odd row.
  - col increments; at OUT_W-1 it wraps to 0 and row increments.
- Nth write accepted at edge E:
  - At E+1, state = DRAIN, busy = 1, out_valid = 1, out_data = buf[0].
  - Fixed latency: one bubble cycle.
- DRAIN state:
  - Transfer occurs on an edge with out_valid & out_ready; rd_ptr increments and the next word appears on the same edge (no bubbles).
  - While out_valid & !out_ready, out_data and out_last stay stable.
  - out_last = 1 exactly when rd_ptr = N-1.
- Frame end: on the transfer of the last word, out_valid, out_last and busy drop at that edge. State returns to FILL with row/col/rd_ptr = 0. in_valid is accepted from the next cycle.
- in_finish handling:
  - In FILL with 0 < count < N: err <= 1; row/col cleared; partial frame discarded. No output.
  - With count = 0, or in DRAIN: ignored.
  - If in_valid and in_finish occur in the same cycle, the word is written first and the check uses the incremented count. A finish that coincides with the Nth word is legal.
- in_valid while in DRAIN: word dropped, err <= 1, drain continues unaffected.
- err clears only on rst.
- Arithmetic: none beyond the ReLU clamp; no width change.

Test Plan:
- Serpentine 1..25 streamed, out_ready=1 -> first out_valid one cycle after the 25th write. Output sequence is 1,2,3,4,5, 10,9,8,7,6, 11..15, 20,19,18,17,16, 21..25; out_last only on 25; busy high for 25 cycles; err=0.
- Same frame with out_ready toggling 1,0,0,1 repeating -> identical sequence; out_data stable across stalls; exactly 25 transfers.
- RELU=1, inputs alternating 16'h0040 / 16'hFFC0 -> negative positions read 0, positives unchanged. With RELU=0 -> 16'hFFC0 passed through unchanged.
- 10 words then in_finish -> err=1, out_valid never asserted. Following full frame of 100..124 -> correct raster output; err stays 1.
- in_valid with 16'h7777 during DRAIN -> err=1; 16'h7777 never appears on out_data; frame output intact.
- rst asserted after 12 words drained -> next edge: out_valid=0, busy=0, err=0. New frame is accepted and output correctly.
